// File: rtl/param_data_memory_if.sv
// param_data_memory_if: request/response bundle between the CPU datapath and the data memory.
interface param_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic              Clear;
  logic [DATA_W-1:0] ReadData;
  logic              ReadValid;
  logic              Busy;
  logic              AddrErr;
  modport master (output Address, WriteData, MemRead, MemWrite, Clear,
                  input  ReadData, ReadValid, Busy, AddrErr);
  modport slave  (input  Address, WriteData, MemRead, MemWrite, Clear,
                  output ReadData, ReadValid, Busy, AddrErr);
endinterface

// File: rtl/param_data_memory.sv
// param_data_memory: word memory with sequential pattern init, registered reads, soft clear and range check.
module param_data_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input logic                 clk,
  input logic                 Reset_n,
  param_data_memory_if.slave  bus
);
  localparam int CW = $clog2(DEPTH);
  typedef enum logic {INIT, IDLE} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, waddr, idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata, pat;
  logic              rvalid_q, rvalid_d, aerr_q, aerr_d, we, in_range;
  assign in_range = {1'b0, bus.Address} < (ADDR_W+1)'(DEPTH);
  assign idx      = bus.Address[CW-1:0];
  // Lower half counts up, upper half counts down from zero in two's complement.
  assign pat = cnt_q < CW'(DEPTH/2) ? DATA_W'(cnt_q)
                                    : DATA_W'(0) - DATA_W'(cnt_q - CW'(DEPTH/2));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    aerr_d   = 1'b0;
    we       = 1'b0;
    waddr    = idx;
    wdata    = bus.WriteData;
    if (bus.Clear) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (state_q == INIT) begin
      we      = 1'b1;
      waddr   = cnt_q;
      wdata   = pat;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(DEPTH-1) ? IDLE : INIT;
    end else begin
      rvalid_d = bus.MemRead;
      aerr_d   = (bus.MemRead | bus.MemWrite) & ~in_range;
      rdata_d  = bus.MemRead ? (in_range ? mem[idx] : '0) : rdata_q;
      we       = bus.MemWrite & ~bus.MemRead & in_range;
    end
  end
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign bus.ReadData  = rdata_q;
  assign bus.ReadValid = rvalid_q;
  assign bus.AddrErr   = aerr_q;
  assign bus.Busy      = state_q == INIT;
endmodule
